// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcodes, functs, ALU codes,
// mux selects and the state enum.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b100111;
  localparam logic [5:0] OP_ANDI  = 6'b101111;
  localparam logic [5:0] OP_ORI   = 6'b110010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd3;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  // What kind of ALU operation the current state wants.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_ADD   = 3'd1,
    CLS_SUB   = 3'd2,
    CLS_RTYPE = 3'd3,
    CLS_ITYPE = 3'd4
  } alu_cls_t;

endpackage

// File: rtl/mc_alu_decode.sv
// ALU control decode: (state class, opcode, func) -> alu_crtl and a legal flag.
// Purely combinational, zero latency, no backpressure.
module mc_alu_decode
  import mips_pkg::*;
(
  input  alu_cls_t    cls,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  output logic [3:0]  alu_crtl,
  output logic        legal
);

  always_comb begin
    alu_crtl = ALU_AND;
    legal    = 1'b1;
    case (cls)
      CLS_ADD: alu_crtl = ALU_ADD;
      CLS_SUB: alu_crtl = ALU_SUB;
      CLS_RTYPE: begin
        case (func)
          FN_AND:  alu_crtl = ALU_AND;
          FN_OR:   alu_crtl = ALU_OR;
          FN_ADD:  alu_crtl = ALU_ADD;
          FN_SUB:  alu_crtl = ALU_SUB;
          default: legal    = 1'b0;
        endcase
      end
      CLS_ITYPE: begin
        case (opcode)
          OP_ADDI: alu_crtl = ALU_ADD;
          OP_SUBI: alu_crtl = ALU_SUB;
          OP_ANDI: alu_crtl = ALU_AND;
          OP_ORI:  alu_crtl = ALU_OR;
          default: legal    = 1'b0;
        endcase
      end
      default: alu_crtl = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multi-cycle MIPS datapath; 3-5 cycles per instruction.
// Memory states stall on mem_ready; illegal opcodes/functs park in HALT until reset.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_toreg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_crtl,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic [31:0] retired,
  output logic        halted
);

  state_t      state_q, state_d;
  logic        is_rtype_q, is_bne_q;
  logic [31:0] retired_q;
  logic        retire;
  alu_cls_t    alu_cls;
  logic        alu_legal;
  logic        pc_write_c, ir_write_c, mem_read_c, mem_write_c, reg_write_c;

  mc_alu_decode u_alu_decode (
    .cls      (alu_cls),
    .opcode   (opcode),
    .func     (func),
    .alu_crtl (alu_crtl),
    .legal    (alu_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_RTYPE:                          state_d = S_EXEC_R;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          default:                           state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC_R:   state_d = alu_legal ? S_ALU_WB : S_HALT;
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_HALT;
    endcase
  end

  // Every path back into FETCH finishes an instruction, except a stalled fetch itself.
  assign retire = (state_d == S_FETCH) && (state_q != S_FETCH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      is_rtype_q <= 1'b0;
      is_bne_q   <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        is_rtype_q <= (opcode == OP_RTYPE);
        is_bne_q   <= (opcode == OP_BNE);
      end
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    pc_write_c  = 1'b0;
    ir_write_c  = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_toreg   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    pc_src      = PCSRC_ALU;
    alu_cls     = CLS_NONE;
    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        alu_cls    = CLS_ADD;
        ir_write_c = mem_ready;
        pc_write_c = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_cls   = CLS_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = CLS_ADD;
      end
      S_MEM_RD: begin
        iord       = 1'b1;
        mem_read_c = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_c = 1'b1;
        mem_toreg   = 1'b1;
      end
      S_MEM_WR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_cls   = CLS_RTYPE;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_cls   = CLS_ITYPE;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        reg_dst     = is_rtype_q;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_cls    = CLS_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write_c = is_bne_q ? ~zero : zero;
      end
      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src     = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  // Reset lands the state in FETCH at once; the gate keeps that from issuing a read early.
  assign pc_write  = pc_write_c  & rst;
  assign ir_write  = ir_write_c  & rst;
  assign mem_read  = mem_read_c  & rst;
  assign mem_write = mem_write_c & rst;
  assign reg_write = reg_write_c & rst;

  assign state   = state_q;
  assign retired = retired_q;
  assign halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks instruction classes, stalls, halt,
// reset mid-access and counter wrap against hand-computed values.
module tb_multicycle_control;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  func = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
  logic        reg_dst, mem_toreg, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_crtl, state;
  logic [31:0] retired;
  logic        halted;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .func      (func),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .iord      (iord),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_toreg (mem_toreg),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .alu_crtl  (alu_crtl),
    .pc_src    (pc_src),
    .state     (state),
    .retired   (retired),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] strobes();
    return {pc_write, ir_write, mem_read, mem_write, reg_write};
  endfunction

  initial begin
    int cyc;
    int held;

    // Reset asserted: FETCH state, but all strobes suppressed.
    #2;
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    chk("rst_strobes", strobes(), 0);

    @(posedge clk); #3; rst = 1'b1; #1;
    // ADD: FETCH, DECODE, EXEC_R, ALU_WB, FETCH
    opcode = OP_RTYPE; func = FN_ADD;
    chk("fetch_state", state, 0);
    chk("fetch_strobes", strobes(), 5'b11100);
    chk("fetch_iord", iord, 0);
    chk("fetch_srcb", alu_src_b, 1);
    chk("fetch_alu", alu_crtl, 2);
    chk("fetch_pcsrc", pc_src, 0);
    tick();
    chk("add_dec_state", state, 1);
    chk("add_dec_srcb", alu_src_b, 3);
    chk("add_dec_srca", alu_src_a, 0);
    chk("add_dec_alu", alu_crtl, 2);
    tick();
    chk("add_exr_state", state, 6);
    chk("add_exr_alu", alu_crtl, 2);
    chk("add_exr_srca", alu_src_a, 1);
    chk("add_exr_srcb", alu_src_b, 0);
    tick();
    chk("add_wb_state", state, 8);
    chk("add_wb_regwrite", reg_write, 1);
    chk("add_wb_regdst", reg_dst, 1);
    chk("add_wb_memtoreg", mem_toreg, 0);
    tick();
    chk("add_done_state", state, 0);
    chk("add_retired", retired, 1);

    // Fetch stall: no IR/PC load without mem_ready.
    mem_ready = 1'b0; #1;
    chk("fstall_strobes", strobes(), 5'b00100);
    tick();
    chk("fstall_state", state, 0);
    chk("fstall_retired", retired, 1);

    // LW with three stall cycles in MEM_RD: 8 cycles total.
    mem_ready = 1'b1; opcode = OP_LW; #1;
    cyc = 0; held = 0;
    tick(); cyc++;
    tick(); cyc++;
    chk("lw_ma_state", state, 2);
    chk("lw_ma_srcb", alu_src_b, 2);
    chk("lw_ma_alu", alu_crtl, 2);
    mem_ready = 1'b0;
    tick(); cyc++;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      if (mem_read === 1'b1 && iord === 1'b1 && state === 4'd3) held++;
      tick(); cyc++;
    end
    chk("lw_held", held, 4);
    chk("lw_wb_state", state, 4);
    chk("lw_wb_memtoreg", mem_toreg, 1);
    chk("lw_wb_regdst", reg_dst, 0);
    chk("lw_wb_regwrite", reg_write, 1);
    tick(); cyc++;
    chk("lw_cycles", cyc, 8);
    chk("lw_state_end", state, 0);
    chk("lw_retired", retired, 2);

    // BEQ: taken when zero.
    opcode = OP_BEQ;
    tick(); tick();
    zero = 1'b0; #1;
    chk("beq_nz_pcwrite", pc_write, 0);
    zero = 1'b1; #1;
    chk("beq_state", state, 9);
    chk("beq_z_pcwrite", pc_write, 1);
    chk("beq_pcsrc", pc_src, 1);
    chk("beq_alu", alu_crtl, 3);
    tick();
    chk("beq_retired", retired, 3);

    // BNE: taken when not zero.
    opcode = OP_BNE;
    tick(); tick();
    zero = 1'b1; #1;
    chk("bne_z_pcwrite", pc_write, 0);
    zero = 1'b0; #1;
    chk("bne_nz_pcwrite", pc_write, 1);
    tick();
    chk("bne_state_end", state, 0);
    chk("bne_retired", retired, 4);

    // SW, no stall.
    opcode = OP_SW;
    tick(); tick(); tick();
    chk("sw_state", state, 5);
    chk("sw_strobes", strobes(), 5'b00010);
    chk("sw_iord", iord, 1);
    tick();
    chk("sw_retired", retired, 5);

    // ORI through EXEC_I; rt destination.
    opcode = OP_ORI;
    tick(); tick();
    chk("ori_state", state, 7);
    chk("ori_alu", alu_crtl, 1);
    chk("ori_srcb", alu_src_b, 2);
    tick();
    chk("ori_wb_regdst", reg_dst, 0);
    tick();
    chk("ori_retired", retired, 6);

    // Counter wrap on a J retirement.
    opcode = OP_J;
    force dut.retired_q = 32'hFFFF_FFFF;
    tick();
    release dut.retired_q;
    #1;
    chk("j_preset", retired, 32'hFFFF_FFFF);
    tick();
    chk("j_state", state, 10);
    chk("j_pcwrite", pc_write, 1);
    chk("j_pcsrc", pc_src, 2);
    tick();
    chk("j_wrap", retired, 0);

    // Reset during a stalled store.
    opcode = OP_SW;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("swr_memwrite", mem_write, 1);
    #2; rst = 1'b0; #1;
    chk("swr_rst_memwrite", mem_write, 0);
    chk("swr_rst_state", state, 0);
    chk("swr_rst_strobes", strobes(), 0);
    chk("swr_rst_retired", retired, 0);
    @(posedge clk); #3; rst = 1'b1; mem_ready = 1'b1; #1;
    chk("swr_refetch", mem_read, 1);

    // One J so the later reset has something to clear.
    opcode = OP_J;
    tick(); tick(); tick();
    chk("j2_retired", retired, 1);

    // Illegal opcode: HALT is sticky and silent.
    opcode = 6'b111111;
    tick(); tick();
    held = 0;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      #1;
      if (state === 4'd11 && halted === 1'b1 && strobes() === 5'd0) held++;
      tick();
    end
    chk("halt_cycles", held, 20);
    chk("halt_retired", retired, 1);
    #2; rst = 1'b0; #1;
    chk("halt_rst_state", state, 0);
    chk("halt_rst_halted", halted, 0);
    chk("halt_rst_retired", retired, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
